// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizing for the two-requester FIFO write arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefDepth    = 16;
  localparam int unsigned DefMaxBurst = 4;

endpackage

// File: rtl/rr_burst_sel.sv
// Round-robin owner selection with a burst cap that only applies while the
// other requester is waiting; holds everything while the FIFO has no room.
module rr_burst_sel
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic can_wr,
  output logic gnt0,
  output logic gnt1
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_q, last_d;  // 1 = requester 1 was granted most recently
  logic          grant;
  logic          grant_id;

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    last_d   = last_q;
    grant    = 1'b0;
    grant_id = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant    = 1'b1;
          grant_id = (req0 && req1) ? ~last_q : req1;
        end
      end
      StOwn0: begin
        if (req0 && ((burst_q < BW'(MAX_BURST)) || !req1)) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (req1) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end else begin
          state_d = StIdle;
          burst_d = '0;
        end
      end
      StOwn1: begin
        if (req1 && ((burst_q < BW'(MAX_BURST)) || !req0)) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end else if (req0) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else begin
          state_d = StIdle;
          burst_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        burst_d = '0;
      end
    endcase

    if (!can_wr) begin
      // Full: freeze ownership so the pending requester is served in order later.
      grant   = 1'b0;
      state_d = state_q;
      burst_d = burst_q;
    end else if (grant) begin
      last_d  = grant_id;
      state_d = grant_id ? StOwn1 : StOwn0;
      if (state_d == state_q) begin
        burst_d = (burst_q < BW'(MAX_BURST)) ? burst_q + BW'(1) : burst_q;
      end else begin
        burst_d = BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  assign gnt0 = grant && !grant_id && !rst;
  assign gnt1 = grant && grant_id && !rst;

endmodule

// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter feeding a FIFO: registered write port plus a
// mirrored occupancy count used to stop granting before the FIFO overflows.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic [WIDTH-1:0]         d0,
  output logic                     gnt0,
  input  logic                     req1,
  input  logic [WIDTH-1:0]         d1,
  output logic                     gnt1,
  input  logic                     fifo_rd,
  output logic                     fifo_wr,
  output logic [WIDTH-1:0]         fifo_din,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             fifo_wr_q;
  logic [WIDTH-1:0] fifo_din_q;
  logic [CW-1:0]    count_q, count_d;
  logic [CW:0]      occ;
  logic             can_wr;
  logic             rd_eff;

  // The word already on the write port counts against the room left.
  assign occ    = {1'b0, count_q} + {{CW{1'b0}}, fifo_wr_q};
  assign can_wr = occ < (CW + 1)'(DEPTH);

  rr_burst_sel #(
    .MAX_BURST(MAX_BURST)
  ) u_sel (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .can_wr(can_wr),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    count_d = count_q;
    rd_eff  = fifo_rd && (count_q != '0);
    if (fifo_wr_q && !rd_eff && (count_q != CW'(DEPTH))) begin
      count_d = count_q + CW'(1);
    end else if (!fifo_wr_q && rd_eff) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_q  <= 1'b0;
      fifo_din_q <= '0;
      count_q    <= '0;
    end else begin
      fifo_wr_q <= gnt0 || gnt1;
      if (gnt0) begin
        fifo_din_q <= d0;
      end else if (gnt1) begin
        fifo_din_q <= d1;
      end
      count_q <= count_d;
    end
  end

  assign fifo_wr  = fifo_wr_q;
  assign fifo_din = fifo_din_q;
  assign count    = count_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed and randomized bench for fifo_wr_arb against a cycle-level
// behavioural model of grants, the write pipeline and FIFO occupancy.
module tb_fifo_wr_arb;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, fifo_rd;
  logic [WIDTH-1:0] d0, d1;
  logic             gnt0, gnt1, fifo_wr;
  logic [WIDTH-1:0] fifo_din;
  logic [4:0]       count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner -1 means nobody owns the port.
  int               m_count, m_owner, m_burst, m_last, m_g, obs_g;
  bit               m_wr, m_blocked;
  logic [WIDTH-1:0] m_din;

  int exp_seq [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

  fifo_wr_arb #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .d0      (d0),
    .gnt0    (gnt0),
    .req1    (req1),
    .d1      (d1),
    .gnt1    (gnt1),
    .fifo_rd (fifo_rd),
    .fifo_wr (fifo_wr),
    .fifo_din(fifo_din),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(bit r0, bit r1);
    bit own_req, oth_req;
    if (m_count + int'(m_wr) >= DEPTH) return -1;
    if (m_owner >= 0) begin
      own_req = (m_owner == 1) ? r1 : r0;
      oth_req = (m_owner == 1) ? r0 : r1;
      if (own_req && (m_burst < MAX_BURST || !oth_req)) return m_owner;
      if (oth_req) return 1 - m_owner;
      return -1;
    end
    if (r0 && r1) return 1 - m_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_owner = -1;
    m_burst = 0;
    m_last  = 1;
    m_wr    = 1'b0;
    m_din   = '0;
  endtask

  // Sample 4 time units after the edge that follows input changes.
  task automatic sample();
    #3;
    m_blocked = (m_count + int'(m_wr)) >= DEPTH;
    m_g       = rst ? -1 : exp_grant(req0, req1);
    obs_g     = gnt1 ? 1 : (gnt0 ? 0 : -1);
    chk("gnt0", 32'(gnt0), 32'(m_g == 0));
    chk("gnt1", 32'(gnt1), 32'(m_g == 1));
    chk("one_gnt", 32'(gnt0 & gnt1), 32'(0));
    chk("fifo_wr", 32'(fifo_wr), 32'(m_wr));
    chk("count", 32'(count), 32'(m_count));
    if (m_wr) chk("fifo_din", 32'(fifo_din), 32'(m_din));
  endtask

  task automatic tick();
    bit rd_eff;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      rd_eff = fifo_rd && (m_count > 0);
      if (m_wr && !rd_eff) m_count++;
      else if (!m_wr && rd_eff) m_count--;
      if (m_g >= 0) begin
        if (m_g == m_owner) m_burst = (m_burst < MAX_BURST) ? m_burst + 1 : m_burst;
        else m_burst = 1;
        m_owner = m_g;
        m_last  = m_g;
        m_din   = (m_g == 1) ? d1 : d0;
      end else if (!m_blocked && !req0 && !req1) begin
        m_owner = -1;
      end
      m_wr = (m_g >= 0);
    end
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic renew_data();
    if (m_g == 0) d0 = 8'($urandom);
    if (m_g == 1) d1 = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_rd = 1'b0; d0 = '0; d1 = '0;
    @(posedge clk);
    #1;
    model_reset();
    step();
    sample();
    chk("rst_din", 32'(fifo_din), 32'(0));
    tick();
    rst = 1'b0;

    // Single word from requester 0.
    req0 = 1'b1; d0 = 8'h05;
    sample();
    chk("first_gnt0", 32'(gnt0), 32'(1));
    tick();
    req0 = 1'b0;
    sample();
    chk("first_wr", 32'(fifo_wr), 32'(1));
    chk("first_din", 32'(fifo_din), 32'(5));
    tick();
    sample();
    chk("first_count", 32'(count), 32'(1));
    tick();

    // Both requesting continuously: alternating bursts until full.
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; d0 = 8'($urandom); d1 = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("burst_seq", 32'(obs_g), 32'(exp_seq[i]));
      tick();
      renew_data();
    end
    for (int i = 0; i < 3; i++) step();
    sample();
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_no_gnt", 32'(gnt0 | gnt1), 32'(0));
    tick();

    // One read frees one slot for exactly one grant.
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    sample();
    chk("refill_count", 32'(count), 32'(DEPTH - 1));
    chk("refill_gnt", 32'(gnt0 | gnt1), 32'(1));
    tick();
    renew_data();
    step();
    sample();
    chk("back_full", 32'(count), 32'(DEPTH));
    tick();

    // Reads on an empty FIFO, then simultaneous write and read at 7.
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; step(); rst = 1'b0;
    fifo_rd = 1'b1;
    for (int i = 0; i < 3; i++) step();
    fifo_rd = 1'b0;
    sample();
    chk("rd_empty", 32'(count), 32'(0));
    tick();
    req0 = 1'b1;
    for (int i = 0; i < 20 && !(m_count == 7 && m_wr); i++) begin
      step();
      renew_data();
    end
    fifo_rd = 1'b1; req0 = 1'b0;
    sample();
    chk("pre_wr_rd", 32'(count), 32'(7));
    tick();
    fifo_rd = 1'b0;
    sample();
    chk("wr_rd_hold", 32'(count), 32'(7));
    tick();

    // Reset while requester 1 owns mid-burst with a word in flight.
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      renew_data();
    end
    rst = 1'b1;
    sample();
    chk("rst_gnt", 32'(gnt0 | gnt1), 32'(0));
    tick();
    rst = 1'b0;
    sample();
    chk("rst_drop_wr", 32'(fifo_wr), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_first_gnt0", 32'(gnt0), 32'(1));
    tick();
    renew_data();

    // Random traffic: slow reader first so the FIFO fills, then a fast one.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      fifo_rd = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
      if (!req0 || m_g == 0) begin
        req0 = ($urandom_range(0, 2) != 0);
        d0   = 8'($urandom);
      end
      if (!req1 || m_g == 1) begin
        req1 = ($urandom_range(0, 2) != 0);
        d1   = 8'($urandom);
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; fifo_rd = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
